// File: rtl/satarx_crc_pkg.sv
// Shared SATA link-layer CRC definitions: default generator/seed and the
// single-dword CRC-32 advance used by both the RX checker and the TX generator.
package satarx_crc_pkg;

  localparam int          DWORD_W       = 32;
  localparam logic [31:0] SATA_CRC_POLY = 32'h04c1_1db7;
  localparam logic [31:0] SATA_CRC_INIT = 32'h5232_5032;

  // MSB-first, no reflection, no final XOR; one call advances over a full dword.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                           input logic [31:0] data_in,
                                           input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int k = 31; k >= 0; k--) begin
      fb = c[31] ^ data_in[k];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/satarx_crc_if.sv
// AXI-Stream style dword channel used on both sides of the RX CRC checker.
interface satarx_crc_if;
  import satarx_crc_pkg::*;

  logic               TVALID;
  logic               TREADY;
  logic [DWORD_W-1:0] TDATA;
  logic               TLAST;
  logic               TUSER;

  modport master (output TVALID, TDATA, TLAST, TUSER, input TREADY);
  modport slave  (input TVALID, TDATA, TLAST, TUSER, output TREADY);

endinterface

// File: rtl/satarx_crc_step.sv
// Combinational 32-bit CRC advance over one dword; shared with the TX CRC generator.
module satarx_crc_step
  import satarx_crc_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL = SATA_CRC_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_step(crc_in, data_in, POLYNOMIAL);
  end

endmodule

// File: rtl/satarx_crc.sv
// SATA RX CRC checker: strips the trailing CRC dword, forwards payload one beat
// late through a hold register, and flags a mismatch on the last payload beat.
module satarx_crc
  import satarx_crc_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL   = SATA_CRC_POLY,
  parameter logic [31:0] INITIAL      = SATA_CRC_INIT,
  parameter bit          OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  satarx_crc_if.slave  S_AXIS,
  satarx_crc_if.master M_AXIS,
  output logic        o_crc_err,
  output logic        o_short
);

  logic [31:0] hold;
  logic        hold_valid;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        s_accept;
  logic        mismatch;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_user;

  satarx_crc_step #(
    .POLYNOMIAL(POLYNOMIAL)
  ) u_step (
    .crc_in  (crc),
    .data_in (S_AXIS.TDATA),
    .crc_out (crc_next)
  );

  assign S_AXIS.TREADY = !m_valid || M_AXIS.TREADY;
  assign s_accept      = S_AXIS.TVALID && S_AXIS.TREADY;
  assign mismatch      = (S_AXIS.TDATA != crc);

  assign M_AXIS.TVALID = m_valid;
  assign M_AXIS.TDATA  = m_data;
  assign M_AXIS.TLAST  = m_last;
  assign M_AXIS.TUSER  = m_user;

  // The CRC dword itself never enters hold; it only closes out the held beat.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      crc        <= INITIAL;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_user     <= 1'b0;
      o_crc_err  <= 1'b0;
      o_short    <= 1'b0;
    end else begin
      o_crc_err <= 1'b0;
      o_short   <= 1'b0;
      if (s_accept) begin
        if (!hold_valid) begin
          m_valid <= 1'b0;
          if (OPT_LOWPOWER) begin
            m_data <= '0;
            m_last <= 1'b0;
            m_user <= 1'b0;
          end
          if (S_AXIS.TLAST) begin
            o_short <= 1'b1;
            crc     <= INITIAL;
          end else begin
            hold       <= S_AXIS.TDATA;
            hold_valid <= 1'b1;
            crc        <= crc_next;
          end
        end else begin
          m_valid <= 1'b1;
          m_data  <= hold;
          m_last  <= S_AXIS.TLAST;
          m_user  <= S_AXIS.TLAST && mismatch;
          if (S_AXIS.TLAST) begin
            hold_valid <= 1'b0;
            crc        <= INITIAL;
            o_crc_err  <= mismatch;
          end else begin
            hold <= S_AXIS.TDATA;
            crc  <= crc_next;
          end
        end
      end else if (M_AXIS.TREADY) begin
        m_valid <= 1'b0;
        if (OPT_LOWPOWER) begin
          m_data <= '0;
          m_last <= 1'b0;
          m_user <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_satarx_crc.sv
// Directed bench for satarx_crc: hand-computed CRC vectors, short frames,
// randomized backpressure, mid-frame reset and the default seed.
module tb_satarx_crc;

  localparam logic [31:0] POLY         = 32'h04c1_1db7;
  localparam logic [31:0] INIT_DEFAULT = 32'h5232_5032;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic crc_err0, short0, crc_err1, short1;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int err_count = 0;
  int short_count = 0;
  int stall_bad = 0;
  bit bp_enable = 1'b0;

  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic        obs_user[$];
  int          obs_cycle[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  satarx_crc_if s0 ();
  satarx_crc_if m0 ();
  satarx_crc_if s1 ();
  satarx_crc_if m1 ();

  satarx_crc #(.INITIAL(32'h0000_0000)) dut0 (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXIS       (s0),
    .M_AXIS       (m0),
    .o_crc_err    (crc_err0),
    .o_short      (short0)
  );

  // Second instance keeps the default seed and mirrors dut0's input stream.
  satarx_crc dut1 (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXIS       (s1),
    .M_AXIS       (m1),
    .o_crc_err    (crc_err1),
    .o_short      (short1)
  );

  assign s1.TVALID = s0.TVALID;
  assign s1.TDATA  = s0.TDATA;
  assign s1.TLAST  = s0.TLAST;
  assign s1.TUSER  = 1'b0;
  assign m1.TREADY = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (m0.TVALID && m0.TREADY) begin
      obs_data.push_back(m0.TDATA);
      obs_last.push_back(m0.TLAST);
      obs_user.push_back(m0.TUSER);
      obs_cycle.push_back(cycle);
    end
    if (crc_err0) err_count++;
    if (short0) short_count++;
    if (prev_stall && (!m0.TVALID || {m0.TDATA, m0.TLAST, m0.TUSER} != prev_word)) stall_bad++;
    prev_stall = m0.TVALID && !m0.TREADY;
    prev_word  = {m0.TDATA, m0.TLAST, m0.TUSER};
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_enable) m0.TREADY = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] model_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 31; k >= 0; k--) begin
      if (r[31] ^ d[k]) r = (r << 1) ^ POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic l);
    bit ok;
    int budget;
    budget = 1000;
    s0.TVALID = 1'b1;
    s0.TDATA  = d;
    s0.TLAST  = l;
    do begin
      @(negedge clk);
      ok = s0.TREADY;
      @(posedge clk);
      #1;
      budget--;
    end while (!ok && budget > 0);
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    s0.TVALID = 1'b0;
    s0.TDATA  = '0;
    s0.TLAST  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearObs();
    obs_data.delete();
    obs_last.delete();
    obs_user.delete();
    obs_cycle.delete();
  endtask

  initial begin
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [31:0] c;
    logic [31:0] d;
    int          len;
    int          err_before;
    int          bad;
    int          users;

    s0.TVALID = 1'b0;
    s0.TDATA  = '0;
    s0.TLAST  = 1'b0;
    s0.TUSER  = 1'b0;
    m0.TREADY = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", m0.TVALID, 0);
    checkOutput("rst_m_data", m0.TDATA, 0);
    checkOutput("rst_m_last", m0.TLAST, 0);
    checkOutput("rst_m_user", m0.TUSER, 0);
    checkOutput("rst_crc_err", crc_err0, 0);
    checkOutput("rst_short", short0, 0);
    checkOutput("rst_s_ready", s0.TREADY, 1);
    checkOutput("rst_dut1_idle", {m1.TVALID, crc_err1, short1, s1.TREADY}, 4'b0001);
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] zero vector");
    clearObs();
    applyStimulus(32'h0000_0000, 1'b0);
    checkOutput("zero_no_early_beat", m0.TVALID, 0);
    applyStimulus(32'h0000_0000, 1'b1);
    checkOutput("zero_last_latency", {m0.TVALID, m0.TLAST}, 2'b11);
    idleCycles(3);
    checkOutput("zero_count", obs_data.size(), 1);
    checkOutput("zero_data", obs_data[0], 32'h0);
    checkOutput("zero_last", obs_last[0], 1);
    checkOutput("zero_user", obs_user[0], 0);
    checkOutput("zero_err", err_count, 0);
    checkOutput("zero_idle_lowpower", {m0.TVALID, m0.TDATA, m0.TLAST, m0.TUSER}, 0);

    $display("[TB] unit vector");
    clearObs();
    applyStimulus(32'h0000_0001, 1'b0);
    applyStimulus(32'h04C1_1DB7, 1'b1);
    idleCycles(3);
    checkOutput("unit_good_count", obs_data.size(), 1);
    checkOutput("unit_good_data", obs_data[0], 32'h1);
    checkOutput("unit_good_user", obs_user[0], 0);
    checkOutput("unit_good_err", err_count, 0);

    clearObs();
    applyStimulus(32'h0000_0001, 1'b0);
    applyStimulus(32'h04C1_1DB6, 1'b1);
    idleCycles(3);
    checkOutput("unit_bad_count", obs_data.size(), 1);
    checkOutput("unit_bad_last", obs_last[0], 1);
    checkOutput("unit_bad_user", obs_user[0], 1);
    checkOutput("unit_bad_err_pulses", err_count, 1);

    $display("[TB] two-dword frame");
    clearObs();
    applyStimulus(32'h0000_0000, 1'b0);
    applyStimulus(32'h0000_0002, 1'b0);
    applyStimulus(32'h0982_3B6E, 1'b1);
    idleCycles(3);
    checkOutput("two_count", obs_data.size(), 2);
    checkOutput("two_data0", obs_data[0], 32'h0);
    checkOutput("two_last0", obs_last[0], 0);
    checkOutput("two_data1", obs_data[1], 32'h2);
    checkOutput("two_last1", obs_last[1], 1);
    checkOutput("two_user1", obs_user[1], 0);
    checkOutput("two_spacing", obs_cycle[1] - obs_cycle[0], 1);
    checkOutput("two_err", err_count, 1);

    $display("[TB] short frame");
    clearObs();
    applyStimulus(32'hDEAD_BEEF, 1'b1);
    idleCycles(3);
    checkOutput("short_no_beat", obs_data.size(), 0);
    checkOutput("short_pulses", short_count, 1);
    c = model_step(model_step(32'h0, 32'h1234_5678), 32'h9ABC_DEF0);
    applyStimulus(32'h1234_5678, 1'b0);
    applyStimulus(32'h9ABC_DEF0, 1'b0);
    applyStimulus(c, 1'b1);
    idleCycles(3);
    checkOutput("after_short_count", obs_data.size(), 2);
    checkOutput("after_short_data1", obs_data[1], 32'h9ABC_DEF0);
    checkOutput("after_short_user", obs_user[1], 0);
    checkOutput("after_short_err", err_count, 1);
    checkOutput("after_short_shorts", short_count, 1);

    $display("[TB] backpressure");
    clearObs();
    err_before = err_count;
    stall_bad  = 0;
    bp_enable  = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 6);
      c   = 32'h0;
      for (int i = 0; i < len; i++) begin
        d = $urandom;
        exp_data.push_back(d);
        exp_last.push_back(i == len - 1);
        c = model_step(c, d);
        applyStimulus(d, 1'b0);
      end
      applyStimulus(c, 1'b1);
    end
    bp_enable = 1'b0;
    idleCycles(1);
    m0.TREADY = 1'b1;
    idleCycles(20);
    checkOutput("bp_count", obs_data.size(), exp_data.size());
    bad   = 0;
    users = 0;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
      if (obs_user[i] !== 1'b0) users++;
    end
    checkOutput("bp_order", bad, 0);
    checkOutput("bp_user_flags", users, 0);
    checkOutput("bp_err_pulses", err_count - err_before, 0);
    checkOutput("bp_stall_stable", stall_bad, 0);

    $display("[TB] reset mid-frame");
    clearObs();
    err_before = err_count;
    applyStimulus(32'hAAAA_0001, 1'b0);
    applyStimulus(32'hAAAA_0002, 1'b0);
    checkOutput("mid_first_beat", {m0.TVALID, m0.TDATA}, {1'b1, 32'hAAAA_0001});
    s0.TVALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_outputs", {m0.TVALID, m0.TDATA, m0.TLAST, m0.TUSER, crc_err0, short0}, 0);
    #2;
    rst = 1'b0;
    idleCycles(2);
    clearObs();
    c = model_step(model_step(32'h0, 32'h5555_0003), 32'h5555_0004);
    applyStimulus(32'h5555_0003, 1'b0);
    applyStimulus(32'h5555_0004, 1'b0);
    applyStimulus(c, 1'b1);
    idleCycles(3);
    checkOutput("post_rst_count", obs_data.size(), 2);
    checkOutput("post_rst_data0", obs_data[0], 32'h5555_0003);
    checkOutput("post_rst_user", obs_user[1], 0);
    checkOutput("post_rst_err", err_count - err_before, 0);

    $display("[TB] default seed");
    applyStimulus(32'h0000_0000, 1'b0);
    applyStimulus(model_step(INIT_DEFAULT, 32'h0), 1'b1);
    checkOutput("seed_dut1_beat", {m1.TVALID, m1.TLAST, m1.TUSER}, 3'b110);
    checkOutput("seed_dut0_user", m0.TUSER, 1);
    checkOutput("seed_dut1_err", crc_err1, 0);
    idleCycles(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/satarx_crc.md
# satarx_crc

Receive-side CRC checker, directly downstream of the RX descrambler in the SATA link layer. Consumes descrambled frame dwords, where the final dword of each frame is the CRC. Forwards only the payload dwords, with the CRC dword stripped. Flags a CRC mismatch on the last payload beat and emits status pulses for frame statistics.

## Interface
- POLYNOMIAL, 32'h04c1_1db7: CRC-32 generator, MSB-first, no reflection, no final XOR.
- INITIAL, 32'h5232_5032: CRC seed at the start of every frame.
- OPT_LOWPOWER, 1'b1: when set, zero M_AXIS_TDATA/TLAST/TUSER whenever M_AXIS_TVALID is low.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TVALID  in  1  descrambled dword valid.
- S_AXIS_TREADY  out  1  = !M_AXIS_TVALID || M_AXIS_TREADY.
- S_AXIS_TDATA  in  32  descrambled dword.
- S_AXIS_TLAST  in  1  marks the CRC dword, the last of the frame.
- M_AXIS_TVALID  out  1  payload dword valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  32  payload dword.
- M_AXIS_TLAST  out  1  last payload dword of the frame.
- M_AXIS_TUSER  out  1  CRC mismatch; meaningful only with M_AXIS_TLAST.
- o_crc_err  out  1  one-cycle pulse when a mismatching frame's last beat is loaded into M.
- o_short  out  1  one-cycle pulse when a frame consisting only of a CRC dword is dropped.

## Operation
- Internal state:
  - hold register (32 bits) plus hold_valid flag.
  - crc register (32 bits), covering every dword accepted into hold in the current frame.
- CRC step over one dword:
  - for k = 31 down to 0: fb = crc[31] ^ d[k]; crc = {crc[30:0],0} ^ (fb ? POLYNOMIAL : 0).
  - Implemented as a combinational function.
- On an accepted S beat (TVALID && TREADY):
  - Case !hold_valid, !TLAST: hold <= data; hold_valid <= 1; crc <= step(crc, data); M loads empty (TVALID 0).
  - Case !hold_valid, TLAST: dword dropped; o_short pulses; crc <= INITIAL; M loads empty.
  - Case hold_valid, !TLAST: M <= {hold, LAST 0, USER 0}; hold <= data; crc <= step(crc, data).
  - Case hold_valid, TLAST: M <= {hold, LAST 1, USER (data != crc)}; hold_valid <= 0; crc <= INITIAL; o_crc_err <= (data != crc).
- No S beat while the M slot is free: M_AXIS_TVALID <= 0.
- The hold register never drains on its own; it drains only on the next accepted beat.
- Reset forces the following, and discards any partial frame (the next beat starts a new frame):
  - M_AXIS_TVALID 0, TDATA 0, TLAST 0, TUSER 0.
  - hold_valid 0, hold 0.
  - crc INITIAL.
  - o_crc_err 0, o_short 0.

## Timing
- Throughput is one dword per clock with no bubbles inside a frame.
- Payload dword N appears on M the cycle after dword N+1 is accepted.
- The last payload dword appears the cycle after the CRC dword is accepted.
- Back-to-back frames need no idle cycles. A new frame's first dword may be accepted the cycle after the previous CRC dword.
- M holds TDATA/TLAST/TUSER stable while TVALID && !TREADY.
  - In that case S_AXIS_TREADY is low and hold/crc are frozen.
- o_crc_err and o_short are registered and coincide with the cycle the M register loads (o_short with an empty load).
- Reset asserted mid-frame:
  - Outputs clear asynchronously.
  - After deassertion, an in-flight upstream frame is treated as new. A resulting CRC mismatch is the expected outcome.

## Structure
- The CRC step function and the default POLYNOMIAL/INITIAL constants belong in the shared SATA link package. The TX CRC generator uses the same ones.
- One sub-module is natural: satarx_crc_step, a combinational 32-bit CRC advance (crc_in, data_in -> crc_out). It is shared with the TX CRC generator.
- Everything else stays flat in this module.

## Test plan
- Zero vector (INITIAL=0): frame {0x00000000, CRC 0x00000000}, M_AXIS_TREADY=1.
  - Required: one M beat, data 0, LAST 1, USER 0; o_crc_err stays 0.
- Unit vector (INITIAL=0): frame {0x00000001, 0x04C11DB7}.
  - Required: USER 0.
  - Same frame with CRC 0x04C11DB6: USER 1 and o_crc_err pulses once.
- Two-dword frame (INITIAL=0): frame {0x00000000, 0x00000002, CRC 0x09823B6E}.
  - Required: M beats 0x00000000 (LAST 0), then 0x00000002 (LAST 1, USER 0), one cycle apart.
- Short frame: a lone TLAST dword.
  - Required: no M beat; o_short pulses once.
  - The following good frame checks clean.
- Backpressure: random M_AXIS_TREADY at 50% over 100 random-length frames, with CRCs from the bench model.
  - Required: payload order, count and stability under stall match the model; zero USER flags.
- Reset mid-frame: assert S_AXI_ARESET after two accepted payload dwords.
  - Required: M_AXIS_TVALID drops immediately and all outputs are 0.
  - A subsequent full frame checks clean.
